// File: rtl/alu4bit_op_sequencer_if.sv
// Command and response handshake bundle between a host stream and the ALU op sequencer.
// master = host side (issues commands, consumes responses); slave = sequencer side.
interface alu4bit_op_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_sel;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;
    logic [2:0] rsp_sel;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sel,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_sel,
        input  rsp_ready
    );
endinterface

// File: rtl/alu4bit_op_sequencer.sv
// Drives one external combinational alu4bit: latches a command onto the ALU pins, waits a
// settle window, captures result/carry/zero and hands them back on a valid/ready response port.
module alu4bit_op_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu4bit_op_sequencer_if.slave  bus,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [2:0]             alu_sel,
    input  logic [3:0]             alu_result,
    input  logic                   alu_carry,
    input  logic                   alu_zero,
    output logic [CNT_W-1:0]       op_count,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       cmd_hs;
    logic       rsp_hs;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + CNT_W'(1);
    endfunction

    // Accepting in RESP is only legal when the pending response leaves in the same cycle.
    assign bus.cmd_ready = rst_n & ((state == IDLE) | ((state == RESP) & bus.rsp_ready));
    assign cmd_hs        = bus.cmd_valid & bus.cmd_ready;
    assign rsp_hs        = bus.rsp_valid & bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_sel        <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_sel    <= '0;
            op_count       <= '0;
            busy           <= 1'b0;
        end else begin
            if (rsp_hs) begin
                op_count <= sat_inc(op_count);
            end

            // ALU pins keep the last accepted command; they are never cleared after a response.
            if (cmd_hs) begin
                alu_a      <= bus.cmd_a;
                alu_b      <= bus.cmd_b;
                alu_sel    <= bus.cmd_sel;
                settle_cnt <= 4'd1;
            end

            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        state <= SETTLE;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        bus.rsp_result <= alu_result;
                        bus.rsp_carry  <= alu_carry;
                        bus.rsp_zero   <= alu_zero;
                        bus.rsp_sel    <= alu_sel;
                        bus.rsp_valid  <= 1'b1;
                        state          <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                RESP: begin
                    // A back-to-back command still has to settle, so valid drops either way.
                    if (rsp_hs) begin
                        bus.rsp_valid <= 1'b0;
                        if (cmd_hs) begin
                            state <= SETTLE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu4bit_op_sequencer.sv
// Bench for alu4bit_op_sequencer: behavioural ALU on the alu_* pins, timestamp-based reference
// model of the sequencer, directed literal cases followed by a randomized run.
module tb_alu4bit_op_sequencer;
    localparam int S = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu4bit_op_sequencer_if bus();
    alu4bit_op_sequencer_if bus2();

    logic [3:0]  alu_a, alu_b, alu_result, alu_a2, alu_b2, alu_result2;
    logic [2:0]  alu_sel, alu_sel2;
    logic        alu_carry, alu_zero, alu_carry2, alu_zero2, busy, busy2;
    logic [15:0] op_count;
    logic [1:0]  op_count2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural alu4bit: {zero, carry, result}
    function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        logic [4:0] w;
        logic [3:0] r;
        logic       c;
        w = 5'd0;
        c = 1'b0;
        case (sel)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[3:0]; c = w[4]; end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
            default: begin r = {1'b0, a[3:1]}; c = a[0]; end
        endcase
        return {(r == 4'd0), c, r};
    endfunction

    assign {alu_zero, alu_carry, alu_result}    = alu_f(alu_a, alu_b, alu_sel);
    assign {alu_zero2, alu_carry2, alu_result2} = alu_f(alu_a2, alu_b2, alu_sel2);

    assign bus2.cmd_valid = bus.cmd_valid;
    assign bus2.cmd_a     = bus.cmd_a;
    assign bus2.cmd_b     = bus.cmd_b;
    assign bus2.cmd_sel   = bus.cmd_sel;
    assign bus2.rsp_ready = bus.rsp_ready;

    alu4bit_op_sequencer #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .op_count(op_count), .busy(busy)
    );

    alu4bit_op_sequencer #(.SETTLE_CYCLES(S), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2),
        .alu_result(alu_result2), .alu_carry(alu_carry2), .alu_zero(alu_zero2),
        .op_count(op_count2), .busy(busy2)
    );

    // Reference model: at most one op in flight, visible once it is S edges old.
    logic       m_have;
    int         m_age;
    int         m_count;
    logic [3:0] m_a, m_b;
    logic [2:0] m_sel;
    logic       exp_rsp_valid, exp_cmd_ready, m_cmd_hs, m_rsp_hs;
    logic [5:0] exp_alu;

    assign exp_rsp_valid = m_have && (m_age >= S);
    assign exp_cmd_ready = rst_n && (!m_have || (exp_rsp_valid && bus.rsp_ready));
    assign m_cmd_hs      = bus.cmd_valid && exp_cmd_ready;
    assign m_rsp_hs      = exp_rsp_valid && bus.rsp_ready;
    assign exp_alu       = alu_f(m_a, m_b, m_sel);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have  <= 1'b0;
            m_age   <= 0;
            m_count <= 0;
            m_a     <= 4'd0;
            m_b     <= 4'd0;
            m_sel   <= 3'd0;
        end else begin
            if (m_rsp_hs) m_count <= m_count + 1;
            if (m_cmd_hs) begin
                m_have <= 1'b1;
                m_age  <= 0;
                m_a    <= bus.cmd_a;
                m_b    <= bus.cmd_b;
                m_sel  <= bus.cmd_sel;
            end else if (m_rsp_hs) begin
                m_have <= 1'b0;
            end else if (m_have && m_age < S) begin
                m_age <= m_age + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(exp_cmd_ready));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp_valid));
        chk("busy", 32'(busy), 32'(m_have));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("alu_sel", 32'(alu_sel), 32'(m_sel));
        chk("op_count", 32'(op_count), (m_count > 65535) ? 32'd65535 : 32'(m_count));
        chk("op_count_w2", 32'(op_count2), (m_count > 3) ? 32'd3 : 32'(m_count));
        chk("rsp_valid_w2", 32'(bus2.rsp_valid), 32'(exp_rsp_valid));
        if (exp_rsp_valid) begin
            chk("rsp_result", 32'(bus.rsp_result), 32'(exp_alu[3:0]));
            chk("rsp_carry", 32'(bus.rsp_carry), 32'(exp_alu[4]));
            chk("rsp_zero", 32'(bus.rsp_zero), 32'(exp_alu[5]));
            chk("rsp_sel", 32'(bus.rsp_sel), 32'(m_sel));
            chk("rsp_result_w2", 32'(bus2.rsp_result), 32'(exp_alu[3:0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        logic ok;
        ok = 1'b0;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_sel   = sel;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.cmd_valid = 1'b0;
        chk("accept_in_time", 32'(ok), 32'd1);
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                         input int er, input int ec, input int ez);
        send(a, b, sel);
        @(negedge clk);
        chk("lit_settling_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("lit_valid", 32'(bus.rsp_valid), 32'd1);
        chk("lit_result", 32'(bus.rsp_result), 32'(er));
        chk("lit_carry", 32'(bus.rsp_carry), 32'(ec));
        chk("lit_zero", 32'(bus.rsp_zero), 32'(ez));
        chk("lit_sel", 32'(bus.rsp_sel), 32'(sel));
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       took;
        int         idx, nresp;
        int         acc_cyc[5];
        int         res[5];
        int         exp_res[5];
        logic [3:0] ops_b[5];
        logic [2:0] ops_sel[5];

        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 4'd0;
        bus.cmd_b     = 4'd0;
        bus.cmd_sel   = 3'd0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset while the op is settling
        send(4'd5, 4'd3, 3'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();

        do_op(4'd5, 4'd3, 3'd0, 8, 0, 0);
        @(negedge clk);
        chk("lit_count_1", 32'(op_count), 32'd1);
        tick();

        do_op(4'd15, 4'd15, 3'd0, 14, 1, 0);
        do_op(4'd15, 4'd15, 3'd1, 0, 0, 1);
        @(negedge clk);
        chk("lit_count_3", 32'(op_count), 32'd3);
        chk("lit_count_w2_3", 32'(op_count2), 32'd3);
        tick();

        // Backpressure on AND 5,3
        bus.rsp_ready = 1'b0;
        send(4'd5, 4'd3, 3'd2);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_result", 32'(bus.rsp_result), 32'd1);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_count_4", 32'(op_count), 32'd4);
        tick();
        @(negedge clk);
        chk("bp_count_still_4", 32'(op_count), 32'd4);
        chk("lit_count_w2_sat", 32'(op_count2), 32'd3);
        tick();

        // Back-to-back OR/XOR/NOT/LSHIFT/RSHIFT on a=5
        ops_sel = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        ops_b   = '{4'd3, 4'd3, 4'd0, 4'd0, 4'd0};
        exp_res = '{7, 6, 10, 10, 2};
        idx = 0;
        nresp = 0;
        bus.cmd_a     = 4'd5;
        bus.cmd_b     = ops_b[0];
        bus.cmd_sel   = ops_sel[0];
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 40 && nresp < 5; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                res[nresp] = int'(bus.rsp_result);
                nresp++;
            end
            took = bus.cmd_valid && bus.cmd_ready;
            tick();
            if (took) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 5) begin
                    bus.cmd_b   = ops_b[idx];
                    bus.cmd_sel = ops_sel[idx];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
        end
        bus.cmd_valid = 1'b0;
        chk("b2b_accepts", 32'(idx), 32'd5);
        chk("b2b_responses", 32'(nresp), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < nresp) chk("b2b_result", 32'(res[i]), 32'(exp_res[i]));
            if (i > 0 && i < idx) chk("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
        end
        tick();

        // Randomized traffic with occasional resets
        took = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            took = bus.cmd_valid && bus.cmd_ready;
            tick();
            rst_n = (c % 700 == 350) ? 1'b0 : 1'b1;
            if (!bus.cmd_valid || took) begin
                bus.cmd_valid = ($urandom_range(0, 3) != 0);
                bus.cmd_a     = 4'($urandom_range(0, 15));
                bus.cmd_b     = 4'($urandom_range(0, 15));
                bus.cmd_sel   = 3'($urandom_range(0, 7));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rst_n = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
